// File: rtl/uart_fw_loader_pkg.sv
// Shared command codes and FSM state encoding for the UART firmware loader.
package uart_fw_loader_pkg;
  localparam logic [7:0] CMD_LOAD = 8'h01;
  localparam logic [7:0] CMD_RUN  = 8'h02;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEN   = 2'd1,
    ST_DATA  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;
endpackage

// File: rtl/uart_fw_loader_byte_packer.sv
// Packs payload bytes into little-endian 32-bit words with matching byte strobes.
module uart_fw_loader_byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        flush,
  input  logic        clear,
  output logic        word_done,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb
);
  logic [1:0]  lane_q, lane_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  strb_q, strb_d;

  always_comb begin
    lane_d    = lane_q;
    data_d    = data_q;
    strb_d    = strb_q;
    word_done = 1'b0;
    if (clear) begin
      // start every word from zero so unused lanes of a partial word read 0
      lane_d = '0;
      data_d = '0;
      strb_d = '0;
    end else if (byte_valid) begin
      data_d[{lane_q, 3'b000} +: 8] = byte_data;
      strb_d[lane_q]                = 1'b1;
      lane_d                        = lane_q + 2'd1;
      word_done                     = (lane_q == 2'd3) | flush;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_q <= '0;
      data_q <= '0;
      strb_q <= '0;
    end else begin
      lane_q <= lane_d;
      data_q <= data_d;
      strb_q <= strb_d;
    end
  end

  assign wdata = data_q;
  assign wstrb = strb_q;
endmodule

// File: rtl/uart_fw_loader.sv
// Parses LOAD/RUN frames from the UART byte stream and writes the image to firmware memory.
module uart_fw_loader
  import uart_fw_loader_pkg::*;
#(
  parameter int unsigned            FIRM_ADDR_W = 14,
  parameter logic [FIRM_ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  output logic                   rx_ready,
  output logic                   mem_valid,
  output logic [FIRM_ADDR_W-1:0] mem_addr,
  output logic [31:0]            mem_wdata,
  output logic [3:0]             mem_wstrb,
  input  logic                   mem_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   run
);
  localparam logic [32:0]            IMG_MAX   = 33'd1 << FIRM_ADDR_W;
  localparam logic [FIRM_ADDR_W-1:0] ADDR_STEP = FIRM_ADDR_W'(4);

  state_e                 state_q, state_d;
  logic [31:0]            cnt_q, cnt_d;
  logic [1:0]             len_idx_q, len_idx_d;
  logic [FIRM_ADDR_W-1:0] addr_q, addr_d;
  logic                   run_q, run_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   en_q, en_d;

  logic rx_fire;
  logic pk_valid, pk_flush, pk_clear, pk_word_done;

  assign rx_ready = en_q & (state_q != ST_WRITE);
  assign rx_fire  = rx_valid & rx_ready;
  assign pk_valid = rx_fire & (state_q == ST_DATA);
  assign pk_flush = (cnt_q == 32'd1);
  assign pk_clear = (state_q == ST_WRITE) & mem_ready;

  uart_fw_loader_byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .byte_valid (pk_valid),
    .byte_data  (rx_data),
    .flush      (pk_flush),
    .clear      (pk_clear),
    .word_done  (pk_word_done),
    .wdata      (mem_wdata),
    .wstrb      (mem_wstrb)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_idx_d = len_idx_q;
    addr_d    = addr_q;
    run_d     = run_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    en_d      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (rx_fire) begin
          if (rx_data == CMD_LOAD) begin
            state_d   = ST_LEN;
            cnt_d     = '0;
            len_idx_d = '0;
            addr_d    = BASE_ADDR;
          end else if (rx_data == CMD_RUN) begin
            run_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LEN: begin
        if (rx_fire) begin
          // little-endian length: each new byte enters at the top and shifts down
          cnt_d     = {rx_data, cnt_q[31:8]};
          len_idx_d = len_idx_q + 2'd1;
          if (len_idx_q == 2'd3) begin
            if (cnt_d == 32'd0) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else if ({1'b0, cnt_d} > IMG_MAX) begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_DATA;
            end
          end
        end
      end
      ST_DATA: begin
        if (rx_fire) begin
          cnt_d = cnt_q - 32'd1;
          if (pk_word_done) state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (mem_ready) begin
          addr_d = addr_q + ADDR_STEP;
          if (cnt_q == 32'd0) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      len_idx_q <= '0;
      addr_q    <= '0;
      run_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      en_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_idx_q <= len_idx_d;
      addr_q    <= addr_d;
      run_q     <= run_d;
      done_q    <= done_d;
      err_q     <= err_d;
      en_q      <= en_d;
    end
  end

  assign mem_valid = (state_q == ST_WRITE);
  assign mem_addr  = addr_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign run       = run_q;
endmodule

// File: tb/tb_uart_fw_loader.sv
// Randomized frame stimulus checked against a transaction-level model of the loader.
module tb_uart_fw_loader;
  localparam int W = 14;
  localparam logic [W-1:0] BASE = 14'h3FF8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         rx_valid = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_ready;
  logic         mem_valid;
  logic [W-1:0] mem_addr;
  logic [31:0]  mem_wdata;
  logic [3:0]   mem_wstrb;
  logic         mem_ready = 1'b0;
  logic         busy, done, err, run;

  always #5 clk = ~clk;

  uart_fw_loader #(.FIRM_ADDR_W(W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .busy(busy), .done(done), .err(err), .run(run)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [31:0]  d;
    logic [3:0]   s;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  exp_done = 0, exp_err = 0, obs_done = 0, obs_err = 0;
  bit  exp_run = 1'b0;
  int  rmode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Expected memory writes of one LOAD frame, derived directly from the payload bytes.
  task automatic model_load(input logic [7:0] pl[$]);
    wr_t e;
    for (int i = 0; i < pl.size(); i += 4) begin
      e.d = '0;
      e.s = '0;
      for (int k = 0; k < 4; k++) begin
        if (i + k < pl.size()) begin
          e.d = e.d | (32'(pl[i+k]) << (8 * k));
          e.s[k] = 1'b1;
        end
      end
      e.a = BASE + W'(i);
      exp_q.push_back(e);
    end
    exp_done++;
  endtask

  // memory side: 0 = always ready, 1 = ready on 4th valid cycle, 2 = random, 3 = never
  initial begin
    int wcnt;
    wcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!mem_valid) begin
        wcnt = 0;
        mem_ready = (rmode == 0) ? 1'b1 : (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      end else begin
        case (rmode)
          0:       mem_ready = 1'b1;
          1:       mem_ready = (wcnt >= 3);
          2:       mem_ready = 1'($urandom_range(0, 1));
          default: mem_ready = 1'b0;
        endcase
        wcnt++;
      end
    end
  end

  // per-cycle compare against the scoreboard and the protocol rules
  initial begin
    logic         pv, pr;
    logic [W-1:0] pa;
    logic [31:0]  pd;
    logic [3:0]   ps;
    int           vlen;
    wr_t          e;
    pv = 1'b0; pr = 1'b0; pa = '0; pd = '0; ps = '0; vlen = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pv = 1'b0;
        vlen = 0;
      end else begin
        if (done) obs_done++;
        if (err) obs_err++;
        check("run_level", 32'(run), 32'(exp_run));
        if (mem_valid) begin
          vlen++;
          check("rx_ready_while_mem_valid", 32'(rx_ready), 32'd0);
        end
        if (pv && !pr) begin
          check("hold_valid", 32'(mem_valid), 32'd1);
          check("hold_addr", 32'(mem_addr), 32'(pa));
          check("hold_wdata", mem_wdata, pd);
          check("hold_wstrb", 32'(mem_wstrb), 32'(ps));
        end
        if (mem_valid && mem_ready) begin
          if (rmode == 1) check("delayed_valid_cycles", 32'(vlen), 32'd4);
          if (exp_q.size() == 0) begin
            check("unexpected_write", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            check("write_addr", 32'(mem_addr), 32'(e.a));
            check("write_data", mem_wdata, e.d);
            check("write_strb", 32'(mem_wstrb), 32'(e.s));
          end
        end
        if (!mem_valid) vlen = 0;
        pv = mem_valid; pr = mem_ready; pa = mem_addr; pd = mem_wdata; ps = mem_wstrb;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    bit acc;
    repeat (gap) begin @(posedge clk); #1; end
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    acc = 1'b0;
    while (!acc) begin
      @(negedge clk);
      acc = rx_ready;
      @(posedge clk);
      #1;
      n++;
      if (!acc && n > 300) begin
        check("rx_accept_timeout", 32'(n), 32'd0);
        acc = 1'b1;
      end
    end
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic send_load(input logic [7:0] pl[$], input int gmax);
    logic [31:0] len;
    len = 32'(pl.size());
    send_byte(8'h01, $urandom_range(0, gmax));
    send_byte(len[7:0], $urandom_range(0, gmax));
    send_byte(len[15:8], $urandom_range(0, gmax));
    send_byte(len[23:16], $urandom_range(0, gmax));
    send_byte(len[31:24], $urandom_range(0, gmax));
    foreach (pl[i]) send_byte(pl[i], $urandom_range(0, gmax));
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || mem_valid) && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (n >= lim) check("idle_timeout", 32'(n), 32'd0);
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic end_frame(input string tag);
    check({tag, "_done_count"}, 32'(obs_done), 32'(exp_done));
    check({tag, "_err_count"}, 32'(obs_err), 32'(exp_err));
    check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  function automatic wr_t mk(input logic [W-1:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_t e;
    e.a = a; e.d = d; e.s = s;
    return e;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    logic [7:0] pl[$];
    logic [7:0] b;

    #22;
    check("reset_rx_ready", 32'(rx_ready), 32'd0);
    check("reset_mem_valid", 32'(mem_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_run", 32'(run), 32'd0);
    check("reset_addr", 32'(mem_addr), 32'd0);
    check("reset_wdata", mem_wdata, 32'd0);
    check("reset_wstrb", 32'(mem_wstrb), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rx_ready_after_reset", 32'(rx_ready), 32'd1);

    // two full words, memory always ready
    rmode = 0;
    exp_q.push_back(mk(14'h3FF8, 32'h44332211, 4'hF));
    exp_q.push_back(mk(14'h3FFC, 32'h88776655, 4'hF));
    exp_done++;
    pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_load(pl, 0);
    wait_idle(200);
    end_frame("load8");

    // partial last word
    exp_q.push_back(mk(14'h3FF8, 32'hDDCCBBAA, 4'hF));
    exp_q.push_back(mk(14'h3FFC, 32'h000000EE, 4'h1));
    exp_done++;
    pl = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    send_load(pl, 1);
    wait_idle(200);
    end_frame("load5");

    // memory accepts on the 4th cycle; model output pinned against hand values
    rmode = 1;
    pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    model_load(pl);
    check("model_pin_d0", exp_q[0].d, 32'h44332211);
    check("model_pin_a1", 32'(exp_q[1].a), 32'h3FFC);
    send_load(pl, 0);
    wait_idle(300);
    end_frame("load8_delayed");

    // address wrap past the top of the region
    rmode = 0;
    pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
    model_load(pl);
    check("model_pin_wrap_addr", 32'(exp_q[2].a), 32'h0000);
    check("model_pin_wrap_data", exp_q[2].d, 32'h0C0B0A09);
    send_load(pl, 0);
    wait_idle(300);
    end_frame("wrap");

    // bad command
    exp_err++;
    send_byte(8'h07, 0);
    check("bad_cmd_busy", 32'(busy), 32'd0);
    wait_idle(50);
    end_frame("bad_cmd");

    // over-length image: 2**W + 1
    exp_err++;
    send_byte(8'h01, 0);
    check("load_cmd_busy", 32'(busy), 32'd1);
    send_byte(8'h01, 0);
    send_byte(8'h40, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    wait_idle(50);
    end_frame("overlen");

    // RUN sets a sticky level; a second RUN is silent
    send_byte(8'h02, 0);
    exp_run = 1'b1;
    wait_idle(50);
    send_byte(8'h02, 2);
    wait_idle(50);
    end_frame("run");

    // zero-length load
    exp_done++;
    pl = {};
    send_load(pl, 0);
    wait_idle(50);
    end_frame("len0");

    // back-to-back loads both restart at the base address
    rmode = 2;
    pl = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6};
    model_load(pl);
    send_load(pl, 0);
    pl = '{8'hD1, 8'hD2, 8'hD3};
    model_load(pl);
    send_load(pl, 0);
    wait_idle(300);
    end_frame("back_to_back");

    // reset while payload byte 3 is offered
    rmode = 0;
    pl = '{8'h01, 8'h02};
    send_byte(8'h01, 0);
    send_byte(8'h08, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    foreach (pl[i]) send_byte(pl[i], 0);
    rx_valid = 1'b1;
    rx_data  = 8'h03;
    #2;
    reset = 1'b1;
    exp_run = 1'b0;
    #1;
    check("midreset_mem_valid", 32'(mem_valid), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_rx_ready", 32'(rx_ready), 32'd0);
    check("midreset_run", 32'(run), 32'd0);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    exp_q.push_back(mk(BASE, 32'h04030201, 4'hF));
    exp_done++;
    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_load(pl, 0);
    wait_idle(200);
    end_frame("after_midreset");

    // reset while a write is pending
    rmode = 3;
    pl = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    send_load(pl, 0);
    begin
      int n;
      n = 0;
      while (!mem_valid && n < 50) begin @(posedge clk); #1; n++; end
      check("pending_write_seen", 32'(mem_valid), 32'd1);
    end
    #2;
    reset = 1'b1;
    #1;
    check("wreset_mem_valid", 32'(mem_valid), 32'd0);
    check("wreset_wdata", mem_wdata, 32'd0);
    check("wreset_wstrb", 32'(mem_wstrb), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // randomized frames mixed with RUN and bad commands
    rmode = 2;
    for (int f = 0; f < 30; f++) begin
      case ($urandom_range(0, 5))
        0: begin
          send_byte(8'h02, $urandom_range(0, 2));
          exp_run = 1'b1;
        end
        1: begin
          b = 8'($urandom_range(3, 255));
          exp_err++;
          send_byte(b, $urandom_range(0, 2));
        end
        default: begin
          pl = {};
          repeat ($urandom_range(0, 40)) pl.push_back(8'($urandom));
          model_load(pl);
          send_load(pl, 2);
        end
      endcase
      wait_idle(2000);
      end_frame("random");
    end

    // largest legal image: exactly 2**W bytes
    rmode = 0;
    pl = {};
    for (int i = 0; i < (1 << W); i++) pl.push_back(8'(i * 7 + 3));
    model_load(pl);
    send_load(pl, 0);
    wait_idle(50000);
    end_frame("max_image");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
